// File: rtl/operand_fetch16.sv
// operand_fetch16: operand-fetch stage in front of the ALU.
// Selects operands A/B from the register bank's parallel outputs and forwards
// a same-cycle bank write. Fetched pairs are held in a two-entry skid buffer
// (OUT + SKID), so req_ready can be registered and one fetch per cycle is
// still sustained.
// Ports:
//   clk, reset      rising-edge clock, synchronous active-high reset
//   regs_flat       bank outputs, register i at [i*WIDTH +: WIDTH]
//   wr_en, wr_data  bank write port, observed for forwarding
//   req_valid/ready request handshake, rs_a/rs_b/imm/use_imm payload
//   op_valid/ready  operand handshake, op_a/op_b payload from OUT
//   occupancy       entries held (0..2)
module operand_fetch16 #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned NREGS = 16,
  parameter int unsigned SELW  = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NREGS*WIDTH-1:0] regs_flat,
  input  logic [NREGS-1:0]       wr_en,
  input  logic [WIDTH-1:0]       wr_data,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic [SELW-1:0]        rs_a,
  input  logic [SELW-1:0]        rs_b,
  input  logic [WIDTH-1:0]       imm,
  input  logic                   use_imm,
  output logic                   op_valid,
  input  logic                   op_ready,
  output logic [WIDTH-1:0]       op_a,
  output logic [WIDTH-1:0]       op_b,
  output logic [1:0]             occupancy
);

  // Register state
  logic             r_out_valid;
  logic [WIDTH-1:0] r_out_a;
  logic [WIDTH-1:0] r_out_b;
  logic             r_skid_valid;
  logic [WIDTH-1:0] r_skid_a;
  logic [WIDTH-1:0] r_skid_b;
  logic             r_req_ready;
  logic [1:0]       r_occupancy;

  // Next-state values
  logic             w_out_valid_n;
  logic [WIDTH-1:0] w_out_a_n;
  logic [WIDTH-1:0] w_out_b_n;
  logic             w_skid_valid_n;
  logic [WIDTH-1:0] w_skid_a_n;
  logic [WIDTH-1:0] w_skid_b_n;

  logic [WIDTH-1:0] w_regs [NREGS];
  logic [WIDTH-1:0] w_new_a;
  logic [WIDTH-1:0] w_new_b;
  logic             w_accept;
  logic             w_out_free;

  // Unpack the bank outputs
  for (genvar g = 0; g < NREGS; g++) begin : g_unpack
    assign w_regs[g] = regs_flat[g*WIDTH +: WIDTH];
  end

  // Operand select with same-cycle write forwarding; immediate bypasses B
  always_comb begin
    w_new_a = wr_en[rs_a] ? wr_data : w_regs[rs_a];
    w_new_b = wr_en[rs_b] ? wr_data : w_regs[rs_b];
    if (use_imm) begin
      w_new_b = imm;
    end
  end

  assign w_accept   = req_valid && r_req_ready;
  // OUT can take a new value if empty or being consumed this edge
  assign w_out_free = !r_out_valid || op_ready;

  // Skid-buffer next state; FIFO order is SKID before any new accept
  always_comb begin
    w_out_valid_n  = r_out_valid;
    w_out_a_n      = r_out_a;
    w_out_b_n      = r_out_b;
    w_skid_valid_n = r_skid_valid;
    w_skid_a_n     = r_skid_a;
    w_skid_b_n     = r_skid_b;
    if (w_out_free) begin
      if (r_skid_valid) begin
        w_out_valid_n  = 1'b1;
        w_out_a_n      = r_skid_a;
        w_out_b_n      = r_skid_b;
        w_skid_valid_n = 1'b0;
        if (w_accept) begin
          w_skid_valid_n = 1'b1;
          w_skid_a_n     = w_new_a;
          w_skid_b_n     = w_new_b;
        end
      end else if (w_accept) begin
        w_out_valid_n = 1'b1;
        w_out_a_n     = w_new_a;
        w_out_b_n     = w_new_b;
      end else begin
        w_out_valid_n = 1'b0;
      end
    end else if (w_accept) begin
      w_skid_valid_n = 1'b1;
      w_skid_a_n     = w_new_a;
      w_skid_b_n     = w_new_b;
    end
  end

  // State registers; req_ready and occupancy derived from next state
  always_ff @(posedge clk) begin
    if (reset) begin
      r_out_valid  <= 1'b0;
      r_out_a      <= '0;
      r_out_b      <= '0;
      r_skid_valid <= 1'b0;
      r_skid_a     <= '0;
      r_skid_b     <= '0;
      r_req_ready  <= 1'b0;
      r_occupancy  <= 2'd0;
    end else begin
      r_out_valid  <= w_out_valid_n;
      r_out_a      <= w_out_a_n;
      r_out_b      <= w_out_b_n;
      r_skid_valid <= w_skid_valid_n;
      r_skid_a     <= w_skid_a_n;
      r_skid_b     <= w_skid_b_n;
      r_req_ready  <= !w_skid_valid_n;
      r_occupancy  <= 2'(w_out_valid_n) + 2'(w_skid_valid_n);
    end
  end

  assign req_ready = r_req_ready;
  assign op_valid  = r_out_valid;
  assign op_a      = r_out_a;
  assign op_b      = r_out_b;
  assign occupancy = r_occupancy;

endmodule

// File: tb/tb_operand_fetch16.sv
// Directed bench for operand_fetch16: basic fetch, forwarding, immediate,
// backpressure through the skid buffer, streaming, and mid-operation reset.
module tb_operand_fetch16;

  logic         clk;
  logic         reset;
  logic [255:0] regs_flat;
  logic [15:0]  wr_en;
  logic [15:0]  wr_data;
  logic         req_valid;
  logic         req_ready;
  logic [3:0]   rs_a;
  logic [3:0]   rs_b;
  logic [15:0]  imm;
  logic         use_imm;
  logic         op_valid;
  logic         op_ready;
  logic [15:0]  op_a;
  logic [15:0]  op_b;
  logic [1:0]   occupancy;

  logic [15:0]  bank [16];
  int           errors;
  int           checks;

  always_comb begin
    regs_flat = '0;
    for (int i = 0; i < 16; i++) regs_flat[i*16 +: 16] = bank[i];
  end

  operand_fetch16 dut (
    .clk(clk), .reset(reset), .regs_flat(regs_flat), .wr_en(wr_en),
    .wr_data(wr_data), .req_valid(req_valid), .req_ready(req_ready),
    .rs_a(rs_a), .rs_b(rs_b), .imm(imm), .use_imm(use_imm),
    .op_valid(op_valid), .op_ready(op_ready), .op_a(op_a), .op_b(op_b),
    .occupancy(occupancy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic req(input logic [3:0] a, input logic [3:0] b,
                     input logic ui, input logic [15:0] im);
    req_valid = 1'b1; rs_a = a; rs_b = b; use_imm = ui; imm = im;
  endtask

  initial begin
    logic [3:0]  sa, sb;
    logic [15:0] ea, eb;
    errors = 0; checks = 0;
    for (int i = 0; i < 16; i++) bank[i] = 16'h0;
    reset = 1'b1; wr_en = '0; wr_data = '0; req_valid = 1'b0;
    rs_a = '0; rs_b = '0; imm = '0; use_imm = 1'b0; op_ready = 1'b0;

    // Reset
    tick(); tick();
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_op_valid",  32'(op_valid),  32'd0);
    chk("rst_occ",       32'(occupancy), 32'd0);
    chk("rst_op_a",      32'(op_a),      32'd0);
    reset = 1'b0;
    tick();
    chk("post_rst_req_ready", 32'(req_ready), 32'd1);

    // Basic fetch
    bank[3] = 16'h1234; bank[7] = 16'hBEEF;
    req(4'd3, 4'd7, 1'b0, 16'h0);
    tick();
    req_valid = 1'b0;
    chk("basic_valid", 32'(op_valid),  32'd1);
    chk("basic_a",     32'(op_a),      32'h1234);
    chk("basic_b",     32'(op_b),      32'hBEEF);
    chk("basic_occ",   32'(occupancy), 32'd1);
    op_ready = 1'b1;
    tick();
    op_ready = 1'b0;
    chk("basic_drain_valid", 32'(op_valid), 32'd0);
    chk("basic_drain_occ",   32'(occupancy), 32'd0);

    // Forwarding on both sources, then a later write must not disturb OUT
    bank[5] = 16'h0001;
    wr_en = 16'h0020; wr_data = 16'hAAAA;
    req(4'd5, 4'd5, 1'b0, 16'h0);
    tick();
    req_valid = 1'b0;
    bank[5] = 16'hAAAA;
    chk("fwd_a", 32'(op_a), 32'hAAAA);
    chk("fwd_b", 32'(op_b), 32'hAAAA);
    wr_data = 16'h5555;
    tick();
    wr_en = '0; bank[5] = 16'h5555;
    chk("fwd_hold_valid", 32'(op_valid), 32'd1);
    chk("fwd_hold_a",     32'(op_a),     32'hAAAA);
    chk("fwd_hold_b",     32'(op_b),     32'hAAAA);
    op_ready = 1'b1;
    tick();
    op_ready = 1'b0;

    // Immediate: B ignores rs_b and its forwarding
    bank[2] = 16'h0F0F;
    wr_en = 16'h0010; wr_data = 16'h7777;
    req(4'd2, 4'd4, 1'b1, 16'h8000);
    tick();
    req_valid = 1'b0; wr_en = '0; use_imm = 1'b0;
    chk("imm_a", 32'(op_a), 32'h0F0F);
    chk("imm_b", 32'(op_b), 32'h8000);
    op_ready = 1'b1;
    tick();
    op_ready = 1'b0;

    // Backpressure: R1, R2 accepted, R3 held until space frees
    req(4'd0, 4'd0, 1'b1, 16'h1111);
    tick();
    chk("bp_r1_ready", 32'(req_ready), 32'd1);
    req(4'd0, 4'd0, 1'b1, 16'h2222);
    tick();
    chk("bp_full_occ",   32'(occupancy), 32'd2);
    chk("bp_full_ready", 32'(req_ready), 32'd0);
    req(4'd0, 4'd0, 1'b1, 16'h3333);
    tick();
    chk("bp_held_occ",   32'(occupancy), 32'd2);
    chk("bp_held_ready", 32'(req_ready), 32'd0);
    chk("bp_held_b",     32'(op_b),      32'h1111);
    op_ready = 1'b1;
    chk("bp_out1_b", 32'(op_b), 32'h1111);
    tick();
    chk("bp_out2_b",   32'(op_b),      32'h2222);
    chk("bp_out2_occ", 32'(occupancy), 32'd1);
    chk("bp_out2_rdy", 32'(req_ready), 32'd1);
    tick();
    req_valid = 1'b0; use_imm = 1'b0;
    chk("bp_out3_b",   32'(op_b),      32'h3333);
    chk("bp_out3_vld", 32'(op_valid),  32'd1);
    chk("bp_out3_occ", 32'(occupancy), 32'd1);
    tick();
    chk("bp_empty_vld", 32'(op_valid),  32'd0);
    chk("bp_empty_occ", 32'(occupancy), 32'd0);

    // Streaming with op_ready held high
    for (int i = 0; i < 16; i++) bank[i] = 16'($urandom);
    op_ready = 1'b1;
    for (int n = 0; n < 20; n++) begin
      sa = 4'($urandom_range(0, 15));
      sb = 4'($urandom_range(0, 15));
      ea = bank[sa]; eb = bank[sb];
      req(sa, sb, 1'b0, 16'h0);
      tick();
      chk("stream_vld", 32'(op_valid),  32'd1);
      chk("stream_a",   32'(op_a),      32'(ea));
      chk("stream_b",   32'(op_b),      32'(eb));
      chk("stream_occ", 32'(occupancy), 32'd1);
      chk("stream_rdy", 32'(req_ready), 32'd1);
    end
    req_valid = 1'b0;
    tick();
    chk("stream_end_vld", 32'(op_valid), 32'd0);

    // Reset while full
    op_ready = 1'b0;
    req(4'd1, 4'd2, 1'b1, 16'hABCD);
    tick();
    req(4'd1, 4'd2, 1'b1, 16'hDCBA);
    tick();
    chk("rst2_pre_occ", 32'(occupancy), 32'd2);
    reset = 1'b1;
    tick();
    chk("rst2_vld", 32'(op_valid),  32'd0);
    chk("rst2_occ", 32'(occupancy), 32'd0);
    chk("rst2_a",   32'(op_a),      32'd0);
    chk("rst2_b",   32'(op_b),      32'd0);
    chk("rst2_rdy", 32'(req_ready), 32'd0);
    reset = 1'b0; req_valid = 1'b0; use_imm = 1'b0;
    tick();
    chk("rst2_after_rdy", 32'(req_ready), 32'd1);
    chk("rst2_after_vld", 32'(op_valid),  32'd0);
    bank[3] = 16'h1234; bank[7] = 16'hBEEF;
    req(4'd3, 4'd7, 1'b0, 16'h0);
    tick();
    req_valid = 1'b0;
    chk("rst2_next_vld", 32'(op_valid), 32'd1);
    chk("rst2_next_a",   32'(op_a),     32'h1234);
    chk("rst2_next_b",   32'(op_b),     32'hBEEF);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/operand_fetch16.md
# operand_fetch16

Read-side companion to the 16×16 register bank: accepts operand-fetch requests (two source register indices plus optional immediate), selects the operands from the bank's sixteen parallel outputs, and delivers them to the ALU through a registered valid/ready output. A same-cycle write to a source register is forwarded, so the operand never reflects pre-write data. A two-entry skid buffer lets req_ready be registered and still sustain one fetch per cycle.

## Interface
- WIDTH, 16, data width of every register and operand
- NREGS, 16, number of registers in the bank
- SELW, 4, register index width (log2 NREGS)
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high; clock clk
- regs_flat  in  NREGS*WIDTH  bank outputs; register i at bits [i*WIDTH +: WIDTH]
- wr_en  in  NREGS  bank write enables (same signal driving the bank), bit i writes register i
- wr_data  in  WIDTH  bank write port data
- req_valid  in  1  request present
- req_ready  out  1  block can accept a request this cycle
- rs_a  in  SELW  source index for operand A
- rs_b  in  SELW  source index for operand B
- imm  in  WIDTH  immediate value
- use_imm  in  1  1: operand B = imm instead of register rs_b
- op_valid  out  1  operand pair present on op_a/op_b
- op_ready  in  1  ALU consumes the pair this cycle
- op_a  out  WIDTH  operand A
- op_b  out  WIDTH  operand B
- occupancy  out  2  entries held (0, 1 or 2)

## Operation
- Accept: req_valid && req_ready at a rising edge. Consume: op_valid && op_ready at a rising edge.
- Operand value at accept: if wr_en[rs] = 1 that cycle, wr_data (forward); else regs_flat slice rs. Any set bit matching rs forwards, regardless of other bits set.
- use_imm = 1: op_b = imm; rs_b ignored, no forwarding on B.
- Operands are snapshotted at accept; later writes to the same register do not modify buffered entries.
- Storage: output register (OUT) and skid register (SKID), each {valid, a, b}.
- Accepted entry goes to OUT if OUT is empty or consumed in the same cycle and SKID is empty; otherwise to SKID.
- OUT consumed while SKID valid: SKID moves to OUT; an accept that same cycle goes to SKID.
- Order strictly FIFO; no entry dropped or duplicated.
- req_ready = !SKID.valid, registered (derived from next-state SKID valid).
- occupancy = OUT.valid + SKID.valid.
- op_valid = OUT.valid; op_a/op_b driven from OUT only.

## Timing
- Latency: accept at edge N → op_valid = 1 and data stable after edge N.
- Throughput: 1 accept per cycle while op_ready held high.
- op_valid stays high and op_a/op_b stay stable until consumed.
- Reset (sampled at edge): OUT.valid = SKID.valid = 0, op_a = op_b = 0, occupancy = 0, req_ready = 0 during the reset cycle, 1 from the first cycle after reset deasserts. Reset mid-operation discards both entries; requests presented during reset are not accepted.
- Full (occupancy 2): req_ready = 0; a consume that cycle raises req_ready after the edge, not combinationally.
- Simultaneous accept + consume with occupancy 1 (OUT only, SKID empty): new entry goes to OUT, occupancy remains 1.
- No combinational path from req_valid/op_ready to req_ready, or from inputs to op_*.

## Test plan
- Reset then bank r3 = 0x1234, r7 = 0xBEEF; request rs_a = 3, rs_b = 7, use_imm = 0 → one cycle later op_valid = 1, op_a = 0x1234, op_b = 0xBEEF, occupancy = 1.
- Forwarding: r5 = 0x0001, same cycle as accept wr_en = 0x0020, wr_data = 0xAAAA, rs_a = rs_b = 5 → op_a = op_b = 0xAAAA; next cycle write r5 = 0x5555 while held → op_a stays 0xAAAA.
- Immediate: rs_a = 2 (0x0F0F), use_imm = 1, imm = 0x8000, wr_en = 0x0010 → op_b = 0x8000, op_a = 0x0F0F.
- Backpressure: op_ready = 0, issue requests R1, R2, R3 back-to-back → R1, R2 accepted, occupancy = 2, req_ready = 0, R3 held; raise op_ready → outputs R1, R2, R3 in order on consecutive cycles, no duplicates.
- Streaming: op_ready = 1, 20 consecutive requests with random indices → 20 outputs, one per cycle, latency 1, occupancy ≤ 1, values match a reference model.
- Reset with occupancy = 2 → after edge op_valid = 0, occupancy = 0, op_a = op_b = 0; req_ready = 1 the cycle after reset drops; the next request is delivered normally.
